// File: rtl/phy_pkg.sv
// phy_pkg: shared lane widths, comma symbol and serializer state encoding
package phy_pkg;
  localparam int LANE_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;
endpackage

// File: rtl/fifo_lane.sv
// fifo_lane: synchronous FIFO with fill count, head word visible on dout
module fifo_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally at DEPTH; count tracks push minus pop
  always_ff @(posedge clk_4f or negedge reset_L)
    if (!reset_L) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset; only slots below count are ever read
  always_ff @(posedge clk_4f)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/lane_byte_serializer.sv
// lane_byte_serializer: buffers 32-bit lane words and emits them MSB byte first; COM_IDLE_EN selects comma idle fill
module lane_byte_serializer import phy_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [BYTE_W-1:0] IDLE_SYM = COM_SYM,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [LANE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              ready_out,
  output logic              overflow
);
`ifdef COM_IDLE_EN
  localparam logic [BYTE_W-1:0] IDLE_BYTE = IDLE_SYM;
`else
  localparam logic [BYTE_W-1:0] IDLE_BYTE = '0;
`endif
  ser_state_t state;
  logic [1:0] byte_idx;
  logic [LANE_W-BYTE_W-1:0] shift;
  logic [LANE_W-1:0] head;
  logic [AW:0] count;
  logic full, empty, push, pop;
  // a new word starts only when idle or when the previous word's last byte went out
  assign pop       = !empty && (state == IDLE || byte_idx == 2'd0);
  assign push      = valid_in && (!full || pop);
  assign ready_out = count < (AW+1)'(DEPTH - 1);
  fifo_lane #(.WIDTH(LANE_W), .DEPTH(DEPTH)) u_fifo (
    .clk_4f (clk_4f),
    .reset_L(reset_L),
    .push   (push),
    .pop    (pop),
    .din    (data_in),
    .dout   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );
  // serializer FSM: load head word, shift out remaining bytes, wrap byte_idx to 0 after the last
  always_ff @(posedge clk_4f or negedge reset_L)
    if (!reset_L) begin
      state     <= IDLE;
      byte_idx  <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= valid_in && !push;
      if (pop) begin
        state     <= SEND;
        byte_idx  <= 2'd1;
        shift     <= head[LANE_W-BYTE_W-1:0];
        data_out  <= head[LANE_W-1 -: BYTE_W];
        valid_out <= 1'b1;
      end else if (state == SEND && byte_idx != 2'd0) begin
        byte_idx  <= byte_idx + 2'd1;
        shift     <= shift << BYTE_W;
        data_out  <= shift[LANE_W-BYTE_W-1 -: BYTE_W];
        valid_out <= 1'b1;
      end else begin
        state     <= IDLE;
        data_out  <= IDLE_BYTE;
        valid_out <= 1'b0;
      end
    end
endmodule
